des_dec_key_sched: RTL and testbench

Sequential DES key-schedule generator for the decryption datapath. Accepts a 64-bit key, applies PC-1 once, then emits the 16 round subkeys in reverse order (K16 first, K1 last) over a valid/ready stream by rotating the C/D halves right. It sits between the key register and the decryption round engine, which consumes one subkey per round.

---
 rtl/des_dec_key_sched_if.sv | 22 ++
 rtl/des_dec_key_sched.sv | 98 +++++++++
 tb/tb_des_dec_key_sched.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/des_dec_key_sched_if.sv
// Key-in / subkey-out bundle for the DES decryption key scheduler.
// Handshakes: start moves when start && key_ready. A subkey moves on the clock edge where subkey_valid && subkey_ready; the producer holds it unchanged until then.
interface des_dec_key_sched_if;
    logic [64:1] key_in;
    logic        start;
    logic        key_ready;
    logic [48:1] subkey;
    logic        subkey_valid;
    logic        subkey_ready;
    logic [3:0]  subkey_round;
    logic        subkey_last;

    modport master (
        output key_in, start, subkey_ready,
        input  key_ready, subkey, subkey_valid, subkey_round, subkey_last
    );

    modport slave (
        input  key_in, start, subkey_ready,
        output key_ready, subkey, subkey_valid, subkey_round, subkey_last
    );
endinterface

// File: rtl/des_dec_key_sched.sv
// Emits the DES round subkeys K16..K1 for decryption, one per handshake.
// PC-1 is applied once at start, and the C/D halves then rotate right between rounds.
module des_dec_key_sched (
    input  logic                        clk,
    input  logic                        rst,
    des_dec_key_sched_if.slave          bus,
    output logic                        dbg_state_o
);
    typedef enum logic {IDLE = 1'b0, GEN = 1'b1} state_t;

    // The tables use FIPS bit numbers. FIPS bit n of a w-bit vector sits at index w+1-n.
    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    state_t      state_q;
    logic [28:1] c_q, d_q;
    logic [3:0]  cnt_q;

    logic [56:1] pc1_cd;
    logic [56:1] cd;
    logic [48:1] pc2_k;
    logic        one_step;
    logic [28:1] c_rot, d_rot;
    logic        parity_unused;

    assign parity_unused = ^{bus.key_in[57], bus.key_in[49], bus.key_in[41], bus.key_in[33],
                             bus.key_in[25], bus.key_in[17], bus.key_in[9],  bus.key_in[1]};

    always_comb begin
        pc1_cd = '0;
        for (int i = 1; i <= 56; i++) begin
            pc1_cd[57-i] = bus.key_in[65-PC1[i-1]];
        end
    end

    assign cd = {c_q, d_q};

    always_comb begin
        pc2_k = '0;
        for (int j = 1; j <= 48; j++) begin
            pc2_k[49-j] = cd[57-PC2[j-1]];
        end
    end

    // C0/D0 already give K16. The steps into K15, K8 and K1 are single rotations; every other step rotates by two.
    assign one_step = (cnt_q == 4'd0) || (cnt_q == 4'd7) || (cnt_q == 4'd14);
    assign c_rot    = one_step ? {c_q[1], c_q[28:2]} : {c_q[2:1], c_q[28:3]};
    assign d_rot    = one_step ? {d_q[1], d_q[28:2]} : {d_q[2:1], d_q[28:3]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            c_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        c_q     <= pc1_cd[56:29];
                        d_q     <= pc1_cd[28:1];
                        cnt_q   <= '0;
                        state_q <= GEN;
                    end
                end
                GEN: begin
                    if (bus.subkey_ready) begin
                        if (cnt_q == 4'd15) begin
                            state_q <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                            c_q   <= c_rot;
                            d_q   <= d_rot;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.key_ready    = (state_q == IDLE);
    assign bus.subkey_valid = (state_q == GEN);
    assign bus.subkey       = pc2_k;
    assign bus.subkey_round = 4'd15 - cnt_q;
    assign bus.subkey_last  = (state_q == GEN) && (cnt_q == 4'd15);
    assign dbg_state_o      = state_q;
endmodule

// File: tb/tb_des_dec_key_sched.sv
// Bench for des_dec_key_sched. A reference model builds the forward DES key schedule and pushes it onto the expected queue in reverse order.
module tb_des_dec_key_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dbg_state;

    des_dec_key_sched_if bus ();

    des_dec_key_sched dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SHF [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    int checks = 0;
    int errors = 0;
    logic [47:0] exp_q [$];
    logic [47:0] got_ks [16];

    typedef struct {
        logic [63:0] key;
        int          round;
        logic [47:0] sub;
    } vec_t;
    vec_t vecs [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Forward schedule K1..K16 built with left rotations, then queued in reverse.
    task automatic push_model(input logic [63:0] key);
        logic        c [28];
        logic        d [28];
        logic        tc [28];
        logic        td [28];
        logic        cdb [56];
        logic [47:0] ks [16];
        for (int i = 0; i < 28; i++) begin
            c[i] = key[64-PC1_T[i]];
            d[i] = key[64-PC1_T[i+28]];
        end
        for (int r = 0; r < 16; r++) begin
            for (int s = 0; s < SHF[r]; s++) begin
                tc = c;
                td = d;
                for (int i = 0; i < 28; i++) begin
                    c[i] = tc[(i+1)%28];
                    d[i] = td[(i+1)%28];
                end
            end
            for (int i = 0; i < 28; i++) begin
                cdb[i]    = c[i];
                cdb[i+28] = d[i];
            end
            ks[r] = '0;
            for (int j = 0; j < 48; j++) ks[r][47-j] = cdb[PC2_T[j]-1];
        end
        for (int r = 15; r >= 0; r--) exp_q.push_back(ks[r]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one schedule from idle. ready_pct sets the consumer's accept rate; poke_start drives start and key_in during GEN.
    task automatic run_sched(input logic [63:0] key, input int ready_pct, input bit poke_start);
        int          hs;
        int          cyc;
        bit          stalled;
        bit          r;
        logic [47:0] prev_sub;
        logic [3:0]  prev_round;
        logic [47:0] e;
        exp_q.delete();
        push_model(key);
        check("idle_before_start", {63'd0, bus.key_ready}, 64'd1);
        bus.key_in       = key;
        bus.start        = 1'b1;
        bus.subkey_ready = 1'b0;
        tick();
        bus.start = 1'b0;
        hs = 0;
        cyc = 0;
        stalled = 1'b0;
        prev_sub = '0;
        prev_round = '0;
        while (hs < 16 && cyc < 400) begin
            check("valid_in_gen", {63'd0, bus.subkey_valid}, 64'd1);
            check("key_ready_busy", {63'd0, bus.key_ready}, 64'd0);
            if (stalled) begin
                check("stall_subkey", {16'd0, bus.subkey}, {16'd0, prev_sub});
                check("stall_round", {60'd0, bus.subkey_round}, {60'd0, prev_round});
            end
            r = ($urandom_range(99) < ready_pct);
            if (poke_start) begin
                bus.start  = 1'($urandom_range(1));
                bus.key_in = {$urandom, $urandom};
            end
            bus.subkey_ready = r;
            if (r && bus.subkey_valid) begin
                e = exp_q.pop_front();
                check("subkey", {16'd0, bus.subkey}, {16'd0, e});
                check("round", {60'd0, bus.subkey_round}, 64'(15 - hs));
                check("last", {63'd0, bus.subkey_last}, {63'd0, (hs == 15)});
                got_ks[15-hs] = bus.subkey;
                hs++;
            end
            stalled    = !r;
            prev_sub   = bus.subkey;
            prev_round = bus.subkey_round;
            tick();
            cyc++;
        end
        check("handshake_count", 64'(hs), 64'd16);
        if (ready_pct >= 100) check("cycles_full_rate", 64'(cyc), 64'd16);
        bus.subkey_ready = 1'b0;
        bus.start        = 1'b0;
        check("done_key_ready", {63'd0, bus.key_ready}, 64'd1);
        check("done_valid", {63'd0, bus.subkey_valid}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] last_key;
        bit          have_run;
        int          cyc;
        int          hs;
        int          k1_cyc;
        int          k16b_cyc;
        logic [47:0] e;
        logic [63:0] k1;
        logic [63:0] k2;

        vecs[0] = '{64'h133457799BBCDFF1, 15, 48'hCB3D8B0E17F5};
        vecs[1] = '{64'h133457799BBCDFF1, 1,  48'h79AED9DBC9E5};
        vecs[2] = '{64'h133457799BBCDFF1, 0,  48'h1B02EFFC7072};
        vecs[3] = '{64'h0000000000000000, 15, 48'h000000000000};
        vecs[4] = '{64'h0000000000000000, 0,  48'h000000000000};
        vecs[5] = '{64'hFFFFFFFFFFFFFFFF, 15, 48'hFFFFFFFFFFFF};
        vecs[6] = '{64'hFFFFFFFFFFFFFFFF, 7,  48'hFFFFFFFFFFFF};

        bus.key_in       = '0;
        bus.start        = 1'b0;
        bus.subkey_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_key_ready", {63'd0, bus.key_ready}, 64'd1);
        check("rst_valid", {63'd0, bus.subkey_valid}, 64'd0);
        check("rst_last", {63'd0, bus.subkey_last}, 64'd0);
        check("rst_round", {60'd0, bus.subkey_round}, 64'd15);
        check("rst_subkey", {16'd0, bus.subkey}, 64'd0);
        check("rst_state", {63'd0, dbg_state}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Known-answer table at full rate.
        have_run = 1'b0;
        last_key = '0;
        for (int v = 0; v < 7; v++) begin
            if (!have_run || vecs[v].key != last_key) begin
                run_sched(vecs[v].key, 100, 1'b0);
                last_key = vecs[v].key;
                have_run = 1'b1;
            end
            check($sformatf("kat_%0d_r%0d", v, vecs[v].round), {16'd0, got_ks[vecs[v].round]}, {16'd0, vecs[v].sub});
        end

        // Backpressure, then busy-start pokes.
        run_sched(64'h133457799BBCDFF1, 40, 1'b0);
        check("bp_k16", {16'd0, got_ks[15]}, 64'h0000CB3D8B0E17F5);
        check("bp_k1", {16'd0, got_ks[0]}, 64'h00001B02EFFC7072);
        run_sched(64'h133457799BBCDFF1, 60, 1'b1);
        check("busy_k1", {16'd0, got_ks[0]}, 64'h00001B02EFFC7072);

        // Reset after the 5th handshake.
        bus.key_in       = 64'h133457799BBCDFF1;
        bus.start        = 1'b1;
        tick();
        bus.start        = 1'b0;
        bus.subkey_ready = 1'b1;
        check("pre_rst_state", {63'd0, dbg_state}, 64'd1);
        repeat (5) tick();
        check("pre_rst_valid", {63'd0, bus.subkey_valid}, 64'd1);
        check("pre_rst_round", {60'd0, bus.subkey_round}, 64'd10);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", {63'd0, bus.subkey_valid}, 64'd0);
        check("mid_rst_key_ready", {63'd0, bus.key_ready}, 64'd1);
        check("mid_rst_subkey", {16'd0, bus.subkey}, 64'd0);
        bus.subkey_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        run_sched(64'h0000000000000000, 100, 1'b0);
        for (int i = 0; i < 16; i++) check($sformatf("zero_k%0d", i + 1), {16'd0, got_ks[i]}, 64'd0);

        // Back-to-back with start held high throughout.
        k1 = {$urandom, $urandom};
        k2 = {$urandom, $urandom};
        exp_q.delete();
        push_model(k1);
        push_model(k2);
        bus.key_in       = k1;
        bus.start        = 1'b1;
        bus.subkey_ready = 1'b1;
        tick();
        bus.key_in = k2;
        hs = 0;
        cyc = 0;
        k1_cyc = -100;
        k16b_cyc = 0;
        while (hs < 32 && cyc < 100) begin
            if (bus.subkey_valid) begin
                e = exp_q.pop_front();
                check("b2b_subkey", {16'd0, bus.subkey}, {16'd0, e});
                if (hs == 15) k1_cyc = cyc;
                if (hs == 16) begin
                    k16b_cyc = cyc;
                    bus.start = 1'b0;
                end
                hs++;
            end
            tick();
            cyc++;
        end
        check("b2b_count", 64'(hs), 64'd32);
        check("b2b_gap", 64'(k16b_cyc - k1_cyc), 64'd2);
        bus.start        = 1'b0;
        bus.subkey_ready = 1'b0;
        check("b2b_idle", {63'd0, bus.key_ready}, 64'd1);

        // Random keys against the model.
        for (int n = 0; n < 100; n++) begin
            run_sched({$urandom, $urandom}, $urandom_range(100, 30), 1'($urandom_range(1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
